// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction SRAM loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_WORDS      = 64;
  localparam int DEF_ADDR_W     = 6;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-lane packer: each load fills the lane at byte_idx.
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int BYTES = BYTES_PER_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [7:0]         i_data,
  output logic               o_word_full,
  output logic [8*BYTES-1:0] o_word
);

  localparam int IDX_W = $clog2(BYTES);

  logic [IDX_W-1:0]   r_byte_idx;
  logic [8*BYTES-1:0] r_word;
  logic               w_last_lane;

  assign w_last_lane = (r_byte_idx == IDX_W'(BYTES - 1));
  // Asserted in the cycle whose load completes the word.
  assign o_word_full = i_load && w_last_lane;
  assign o_word      = r_word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_byte_idx <= '0;
      r_word     <= '0;
    end else if (i_clear) begin
      r_byte_idx <= '0;
    end else if (i_load) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (r_byte_idx == IDX_W'(i)) r_word[8*i +: 8] <= i_data;
      end
      r_byte_idx <= w_last_lane ? '0 : r_byte_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into words and writes them through the
// imem SRAM 1rw port, holding the core in reset until the load completes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [DATA_W-1:0] din0,
  output logic              busy,
  output logic              done,
  output logic              core_reset
);

  localparam logic [ADDR_W:0] WORDS_L = (ADDR_W + 1)'(WORDS);

  state_t            r_state,      w_state_nxt;
  logic              r_s_ready,    w_s_ready_nxt;
  logic              r_csb0,       w_csb0_nxt;
  logic              r_web0,       w_web0_nxt;
  logic [ADDR_W-1:0] r_addr0,      w_addr0_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_done,       w_done_nxt;
  logic              r_core_reset, w_core_reset_nxt;
  logic [ADDR_W-1:0] r_word_idx,   w_word_idx_nxt;
  logic [ADDR_W:0]   r_n,          w_n_nxt;

  logic              w_clear;
  logic              w_load;
  logic              w_word_full;
  logic [DATA_W-1:0] w_word;
  logic [ADDR_W:0]   w_n_clamped;
  logic              w_last_word;

  byte_packer #(
    .BYTES (BYTES_PER_WORD)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_clear),
    .i_load      (w_load),
    .i_data      (s_data),
    .o_word_full (w_word_full),
    .o_word      (w_word)
  );

  assign w_n_clamped = (num_words > WORDS_L) ? WORDS_L : num_words;
  assign w_last_word = ({1'b0, r_word_idx} == (r_n - (ADDR_W + 1)'(1)));

  always_comb begin
    w_state_nxt      = r_state;
    w_s_ready_nxt    = 1'b0;
    w_csb0_nxt       = 1'b1;
    w_web0_nxt       = 1'b1;
    w_addr0_nxt      = r_addr0;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_core_reset_nxt = r_core_reset;
    w_word_idx_nxt   = r_word_idx;
    w_n_nxt          = r_n;
    w_clear          = 1'b0;
    w_load           = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_n_nxt        = w_n_clamped;
          w_word_idx_nxt = '0;
          w_clear        = 1'b1;
          if (w_n_clamped == '0) begin
            w_state_nxt      = DONE;
            w_busy_nxt       = 1'b0;
            w_done_nxt       = 1'b1;
            w_core_reset_nxt = 1'b0;
          end else begin
            w_state_nxt      = RECV;
            w_s_ready_nxt    = 1'b1;
            w_busy_nxt       = 1'b1;
            w_done_nxt       = 1'b0;
            w_core_reset_nxt = 1'b1;
          end
        end
      end

      RECV: begin
        w_s_ready_nxt = 1'b1;
        w_load        = s_valid && r_s_ready;
        // 4th handshake: ready drops in the same update that enters WRITE.
        if (w_word_full) begin
          w_state_nxt   = WRITE;
          w_s_ready_nxt = 1'b0;
          w_csb0_nxt    = 1'b0;
          w_web0_nxt    = 1'b0;
          w_addr0_nxt   = r_word_idx;
        end
      end

      WRITE: begin
        if (w_last_word) begin
          w_state_nxt      = DONE;
          w_busy_nxt       = 1'b0;
          w_done_nxt       = 1'b1;
          w_core_reset_nxt = 1'b0;
        end else begin
          w_state_nxt    = RECV;
          w_s_ready_nxt  = 1'b1;
          w_word_idx_nxt = r_word_idx + ADDR_W'(1);
          w_clear        = 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_s_ready    <= 1'b0;
      r_csb0       <= 1'b1;
      r_web0       <= 1'b1;
      r_addr0      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_core_reset <= 1'b1;
      r_word_idx   <= '0;
      r_n          <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_s_ready    <= w_s_ready_nxt;
      r_csb0       <= w_csb0_nxt;
      r_web0       <= w_web0_nxt;
      r_addr0      <= w_addr0_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_core_reset <= w_core_reset_nxt;
      r_word_idx   <= w_word_idx_nxt;
      r_n          <= w_n_nxt;
    end
  end

  assign s_ready    = r_s_ready;
  assign csb0       = r_csb0;
  assign web0       = r_web0;
  assign addr0      = r_addr0;
  assign din0       = w_word;
  assign busy       = r_busy;
  assign done       = r_done;
  assign core_reset = r_core_reset;

endmodule
